// File: rtl/fpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fpu_arbiter
// Purpose : Round-robin sharing of one combinational FPU among NUM_REQ clients,
//           with registered FPU inputs and a tagged valid/ready response.
// Revision: 1.0
// ============================================================================
module fpu_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_A,
  input  logic [32*NUM_REQ-1:0]  req_B,
  input  logic [2*NUM_REQ-1:0]   req_operation,
  output logic [31:0]            fpu_A,
  output logic [31:0]            fpu_B,
  output logic [1:0]             fpu_operation,
  input  logic [31:0]            fpu_ALU_output,
  input  logic                   fpu_overflow,
  input  logic                   fpu_underflow,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_result,
  output logic                   rsp_overflow,
  output logic                   rsp_underflow,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
  logic [1:0]        fpu_op_q, fpu_op_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_result_q, rsp_result_d;
  logic              rsp_ovf_q, rsp_ovf_d, rsp_unf_q, rsp_unf_d;

  logic [31:0]       a_arr  [NUM_REQ];
  logic [31:0]       b_arr  [NUM_REQ];
  logic [1:0]        op_arr [NUM_REQ];

  logic [2*NUM_REQ-1:0] req_rot;
  logic [ID_W:0]        sum;
  logic [ID_W-1:0]      grant_idx;
  logic                 grant_found;

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign a_arr[i]  = req_A[32*i +: 32];
      assign b_arr[i]  = req_B[32*i +: 32];
      assign op_arr[i] = req_operation[2*i +: 2];
    end
  endgenerate

  // Rotate so bit 0 is the requester at rr_ptr; first set bit wins.
  always_comb begin
    req_rot     = {req_valid, req_valid} >> rr_ptr_q;
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_rot[k]) begin
        grant_found = 1'b1;
        sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(NUM_REQ)) begin
          sum = sum - (ID_W+1)'(NUM_REQ);
        end
        grant_idx = sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_found) begin
      req_ready = NUM_REQ'(1) << grant_idx;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    rsp_id_d     = rsp_id_q;
    cnt_d        = cnt_q;
    fpu_a_d      = fpu_a_q;
    fpu_b_d      = fpu_b_q;
    fpu_op_d     = fpu_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_unf_d    = rsp_unf_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          fpu_a_d  = a_arr[grant_idx];
          fpu_b_d  = b_arr[grant_idx];
          fpu_op_d = op_arr[grant_idx];
          id_d     = grant_idx;
          rr_ptr_d = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
          cnt_d    = CNT_W'(SETTLE_CYCLES-1);
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          rsp_result_d = fpu_ALU_output;
          rsp_ovf_d    = fpu_overflow;
          rsp_unf_d    = fpu_underflow;
          rsp_id_d     = id_q;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        // Payload is left untouched so consumers may still read it afterwards.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      rsp_id_q     <= '0;
      cnt_q        <= '0;
      fpu_a_q      <= '0;
      fpu_b_q      <= '0;
      fpu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_unf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      rsp_id_q     <= rsp_id_d;
      cnt_q        <= cnt_d;
      fpu_a_q      <= fpu_a_d;
      fpu_b_q      <= fpu_b_d;
      fpu_op_q     <= fpu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_unf_q    <= rsp_unf_d;
    end
  end

  assign fpu_A         = fpu_a_q;
  assign fpu_B         = fpu_b_q;
  assign fpu_operation = fpu_op_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_overflow  = rsp_ovf_q;
  assign rsp_underflow = rsp_unf_q;
  assign rsp_id        = rsp_id_q;
  assign busy          = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fpu_arbiter
// Purpose : Randomized and directed bench for fpu_arbiter with a queue-based
//           scoreboard and a stand-in combinational FPU.
// Revision: 1.0
// ============================================================================
module tb_fpu_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int S  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [32*N-1:0]   req_A = '0;
  logic [32*N-1:0]   req_B = '0;
  logic [2*N-1:0]    req_operation = '0;
  logic [31:0]       fpu_A, fpu_B, fpu_ALU_output;
  logic [1:0]        fpu_operation;
  logic              fpu_overflow, fpu_underflow;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [31:0]       rsp_result;
  logic              rsp_overflow, rsp_underflow;
  logic [IW-1:0]     rsp_id;
  logic              busy;

  fpu_arbiter #(.NUM_REQ(N), .ID_W(IW), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B), .req_operation(req_operation),
    .fpu_A(fpu_A), .fpu_B(fpu_B), .fpu_operation(fpu_operation),
    .fpu_ALU_output(fpu_ALU_output), .fpu_overflow(fpu_overflow),
    .fpu_underflow(fpu_underflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_underflow(rsp_underflow),
    .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in FPU: exact IEEE results for the directed vectors, a hash otherwise.
  function automatic logic [33:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] op);
    logic [31:0] r;
    if (op == 2'd0 && a == 32'h3F800000 && b == 32'h3F800000)      r = 32'h40000000;
    else if (op == 2'd2 && a == 32'h3FC00000 && b == 32'hBFA00000) r = 32'hBFF00000;
    else if (op == 2'd0 && a == 32'h42FE1000 && b == 32'h41878000) r = 32'h430FF800;
    else if (op == 2'd1 && a == 32'h3F800000 && b == 32'h3FC00000) r = 32'hBF000000;
    else r = (a ^ {b[15:0], b[31:16]}) + ({30'd0, op} * 32'h9E3779B9);
    return {r[31] & r[7], r[30] & r[2], r};
  endfunction

  assign {fpu_overflow, fpu_underflow, fpu_ALU_output} = fpu_fn(fpu_A, fpu_B, fpu_operation);

  typedef struct {
    logic [IW-1:0] id;
    logic [31:0]   res;
    logic          ovf;
    logic          unf;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   obs_id[$];
  int   obs_cyc[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: what the arbiter must show now and do at the coming edge.
  int            m_phase = 0;  // 0 idle, 1 computing, 2 response pending
  int            m_cnt = 0;
  int            m_ptr = 0;
  logic [31:0]   m_a, m_b;
  logic [1:0]    m_op;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0; m_ptr = 0;
      exp_q.delete();
    end else begin
      logic [N-1:0] exp_ready;
      int g;
      exp_ready = '0;
      g = -1;
      if (m_phase == 0) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (g < 0 && req_valid[j]) g = j;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("busy", 64'(busy), 64'(m_phase != 0));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
      if (m_phase != 0) begin
        chk("fpu_A", 64'(fpu_A), 64'(m_a));
        chk("fpu_B", 64'(fpu_B), 64'(m_b));
        chk("fpu_operation", 64'(fpu_operation), 64'(m_op));
      end
      for (int k = 0; k < N; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          obs_id.push_back(k);
          obs_cyc.push_back(cyc);
        end
      end
      if (m_phase == 0) begin
        if (g >= 0) begin
          exp_t e;
          logic [33:0] f;
          m_a  = req_A[32*g +: 32];
          m_b  = req_B[32*g +: 32];
          m_op = req_operation[2*g +: 2];
          f = fpu_fn(m_a, m_b, m_op);
          e.id = IW'(g); e.res = f[31:0]; e.ovf = f[33]; e.unf = f[32];
          e.cyc = cyc + 1 + S;
          exp_q.push_back(e);
          m_phase = 1; m_cnt = S - 1; m_ptr = (g + 1) % N;
        end
      end else if (m_phase == 1) begin
        if (m_cnt == 0) m_phase = 2;
        else m_cnt--;
      end else begin
        if (rsp_ready) m_phase = 0;
      end
    end
  end

  // Monitor: pops the scoreboard when a response appears, checks it while held.
  initial begin
    exp_t cur;
    logic have;
    logic prev;
    have = 1'b0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have = 1'b0;
        prev = 1'b0;
      end else begin
        if (rsp_valid && !prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            have = 1'b0;
            $display("FAIL unexpected_rsp: got id %0d result %0h expected no response", rsp_id, rsp_result);
          end else begin
            cur = exp_q.pop_front();
            have = 1'b1;
            chk("rsp_cycle", 64'(cyc), 64'(cur.cyc));
          end
        end
        if (rsp_valid && have) begin
          chk("rsp_result", 64'(rsp_result), 64'(cur.res));
          chk("rsp_id", 64'(rsp_id), 64'(cur.id));
          chk("rsp_overflow", 64'(rsp_overflow), 64'(cur.ovf));
          chk("rsp_underflow", 64'(rsp_underflow), 64'(cur.unf));
        end
        prev = rsp_valid;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || rsp_valid) && n < 60);
    if (busy || rsp_valid) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy=%0b rsp_valid=%0b expected 0", busy, rsp_valid);
    end
  endtask

  task automatic do_req(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op);
    int n;
    @(posedge clk); #1;
    req_A[32*r +: 32] = a;
    req_B[32*r +: 32] = b;
    req_operation[2*r +: 2] = op;
    req_valid = '0;
    req_valid[r] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[r] && n < 40);
    if (!req_ready[r]) begin
      checks++; errors++;
      $display("FAIL grant_timeout: got req_ready=%0b expected bit %0d", req_ready, r);
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_fpu_A", 64'(fpu_A), 64'd0);
    chk("rst_fpu_B", 64'(fpu_B), 64'd0);
    chk("rst_fpu_operation", 64'(fpu_operation), 64'd0);
    chk("rst_rsp_result", 64'(rsp_result), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_flags", 64'({rsp_overflow, rsp_underflow}), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic collect_grants(input int want);
    int n;
    n = 0;
    while (obs_id.size() < want && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (obs_id.size() < want) begin
      checks++; errors++;
      $display("FAIL grant_count: got %0d grants expected %0d", obs_id.size(), want);
    end
  endtask

  initial begin
    int exp_order[6];
    exp_order = '{0, 1, 2, 3, 0, 1};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    do_req(2, 32'h3F800000, 32'h3F800000, 2'd0);
    do_req(1, 32'h3FC00000, 32'hBFA00000, 2'd2);
    do_req(0, 32'h42FE1000, 32'h41878000, 2'd0);
    do_req(3, 32'h3F800000, 32'h3FC00000, 2'd1);

    // Round robin from a fresh pointer with everyone requesting.
    pulse_reset();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      req_A[32*i +: 32] = $urandom;
      req_B[32*i +: 32] = $urandom;
      req_operation[2*i +: 2] = 2'($urandom_range(0, 3));
    end
    obs_id.delete(); obs_cyc.delete();
    req_valid = '1;
    collect_grants(6);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();
    if (obs_id.size() >= 6) begin
      for (int i = 0; i < 6; i++) chk("rr_order", 64'(obs_id[i]), 64'(exp_order[i]));
      for (int i = 1; i < 6; i++) chk("rr_spacing", 64'(obs_cyc[i] - obs_cyc[i-1]), 64'(S + 2));
    end

    // Random traffic with random backpressure.
    for (int t = 0; t < 300; t++) begin
      @(posedge clk); #1;
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_A[32*i +: 32] = $urandom;
        req_B[32*i +: 32] = $urandom;
        req_operation[2*i +: 2] = 2'($urandom_range(0, 3));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle();

    // Long backpressure while other requesters wait.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = '1;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rsp_valid && n < 40);
      if (!rsp_valid) begin
        checks++; errors++;
        $display("FAIL bp_timeout: got rsp_valid=0 expected 1");
      end
    end
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    // Reset while an operation is in flight.
    do_req(2, 32'h3F800000, 32'h3F800000, 2'd0);
    @(posedge clk); #1;
    req_valid = 4'b0010;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!busy && n < 40);
    end
    pulse_reset();
    obs_id.delete(); obs_cyc.delete();
    @(posedge clk); #1;
    req_valid = '1;
    collect_grants(1);
    if (obs_id.size() >= 1) chk("post_reset_grant", 64'(obs_id[0]), 64'd0);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/fpu_arbiter.md
# fpu_arbiter

Round-robin arbiter and sequencer that shares one combinational FPU instance among NUM_REQ requesters. It grants one request at a time and drives the FPU operand and operation inputs from registers. After a fixed settle time it captures the FPU result and flags, then returns them tagged with the requester index through a valid/ready response port. It sits between client blocks and the single FPU so the FPU's operand/opcode contract stays unchanged.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, requester-index width; must be at least clog2(NUM_REQ)
- SETTLE_CYCLES, 2, cycles the FPU inputs are held before the result is captured (at least 1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  request valid, one bit per requester
- req_ready  out  NUM_REQ  request accepted (one-hot or zero)
- req_A  in  32*NUM_REQ  operand A; requester i uses bits [32i+31:32i]
- req_B  in  32*NUM_REQ  operand B, same packing as req_A
- req_operation  in  2*NUM_REQ  op code per requester: 0 add, 1 sub, 2 mul, 3 div
- fpu_A  out  32  registered operand A to the FPU
- fpu_B  out  32  registered operand B to the FPU
- fpu_operation  out  2  registered op code to the FPU
- fpu_ALU_output  in  32  FPU result
- fpu_overflow  in  1  FPU overflow flag
- fpu_underflow  in  1  FPU underflow flag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_result  out  32  captured result
- rsp_overflow  out  1  captured overflow flag
- rsp_underflow  out  1  captured underflow flag
- rsp_id  out  ID_W  index of the requester that owns the response
- busy  out  1  high whenever the state is not IDLE

## Operation
- Reset:
  - state IDLE, rr_ptr 0, settle counter 0.
  - fpu_A, fpu_B, fpu_operation, rsp_result, rsp_id all 0.
  - rsp_valid, rsp_overflow, rsp_underflow, busy all 0; req_ready is 0.
- Grant: the search starts at rr_ptr and picks the first requester i, in order rr_ptr, rr_ptr+1, … modulo NUM_REQ, with req_valid[i]=1.
- req_ready is combinational: req_ready[g]=1 only in IDLE, only for the granted g. All bits are 0 in every other state.
- Handshake: req_valid[g] and req_ready[g] both high at a rising edge. On that edge:
  - latch req_A/B/operation slice g into fpu_A/B/operation;
  - latch g into the id register;
  - rr_ptr ← (g+1) mod NUM_REQ; settle counter ← SETTLE_CYCLES-1; go to EXEC.
- EXEC:
  - fpu_* outputs are held stable.
  - Counter decrements each edge.
  - On the edge where the counter is 0: capture fpu_ALU_output, fpu_overflow and fpu_underflow into rsp_*; drive the id register to rsp_id; set rsp_valid; go to RESP.
- RESP:
  - rsp_* is held stable.
  - On the edge with rsp_ready=1: clear rsp_valid and go to IDLE.
  - rsp_result, rsp_id and the flags keep their last values after that edge.
- One operation is outstanding at a time; no request is accepted outside IDLE.
- Requesters may drop or change req_valid and operands while not granted. Operands changed after the handshake do not affect the operation in flight.
- No valid request in IDLE: stay in IDLE, rr_ptr unchanged.
- rsp_ready held low: RESP is held indefinitely and all req_ready stay 0.
- rst_n asserted in any state: immediate return to reset values. The in-flight operation is dropped and no response is produced.

## Timing
- Handshake at edge e0: fpu_* are valid after e0; rsp_valid rises at edge e0+SETTLE_CYCLES.
- With rsp_ready=1 the response is consumed at e0+SETTLE_CYCLES+1. The earliest next handshake is edge e0+SETTLE_CYCLES+2.
- Sustained throughput: one operation per SETTLE_CYCLES+2 cycles.
- rsp_valid has no combinational dependence on rsp_ready.

## Test plan
- Reset and idle:
  - Assert rst_n low mid-cycle → all outputs 0 immediately.
  - Release with req_valid=0 for 5 cycles → req_ready=0, busy=0, rsp_valid=0.
- Single add (SETTLE_CYCLES=2):
  - Stimulus: requester 2, A=0x3F800000, B=0x3F800000, op 0, rsp_ready=1.
  - req_ready=4'b0100 in the handshake cycle.
  - rsp_valid rises 2 edges later with rsp_result=0x40000000, rsp_id=2, both flags 0, for exactly one cycle.
- Mixed ops:
  - Requester 1, A=0x3FC00000, B=0xBFA00000, op 2 → rsp_result=0xBFF00000, rsp_id=1.
  - Requester 0, A=0x42FE1000, B=0x41878000, op 0 → rsp_result=0x430FF800, rsp_id=0.
  - Requester 3, A=0x3F800000, B=0x3FC00000, op 1 → rsp_result=0xBF000000.
- Round robin:
  - All four req_valid held high with rsp_ready=1 → grant order 0,1,2,3,0,1.
  - Handshakes are exactly 4 cycles apart.
  - rsp_id follows the same sequence.
- Backpressure:
  - Hold rsp_ready=0 for 10 cycles after rsp_valid rises → rsp_* stable, req_ready=0, busy=1.
  - Raise rsp_ready → rsp_valid clears on the next edge; next grant follows one cycle later.
- Reset mid-operation:
  - Stimulus: assert rst_n low in EXEC, then release.
  - Required: no response for the aborted request, rr_ptr=0, requester 0 wins the next grant.
